// File: rtl/div_sqrt_norm_round.sv
// rtl/div_sqrt_norm_round.sv - normalize, round and pack stage for a single-precision div/sqrt unit
//
// Two-stage pipeline. S1 normalizes the [1,4) mantissa (and, in the denormal
// build, shifts tiny results right). S2 rounds, detects overflow/underflow,
// applies special-value overrides and packs an IEEE single.
//
// Ports:
//   Clk_CI           clock, rising edge
//   Rst_RI           synchronous active-high reset
//   Valid_SI/Ready_SO upstream handshake
//   Kill_SI          flush every in-flight result
//   Sign_DI          result sign
//   Exp_DI[9:0]      signed biased exponent of the Mant_DI[25] position
//   Mant_DI[26:0]    mantissa, value Mant_DI * 2^-25; [1] guard, [0] round
//   Sticky_SI        OR of all bits below round
//   RM_SI[1:0]       0 nearest-even, 1 truncate, 2 +inf, 3 -inf
//   SpecialNaN_SI/SpecialInf_SI/SpecialZero_SI  one-hot result overrides
//   Valid_SO/Ready_SI downstream handshake
//   Result_DO[31:0]  packed IEEE single
//   OF_SO/UF_SO/NX_SO overflow, underflow, inexact (only meaningful with Valid_SO)
//
// Build option: define DIV_SQRT_DENORM_EN to produce subnormal results;
// otherwise tiny results flush to signed zero with UF and NX set.

module div_sqrt_norm_round (
  input  logic              Clk_CI,
  input  logic              Rst_RI,
  input  logic              Valid_SI,
  output logic              Ready_SO,
  input  logic              Kill_SI,
  input  logic              Sign_DI,
  input  logic signed [9:0] Exp_DI,
  input  logic [26:0]       Mant_DI,
  input  logic              Sticky_SI,
  input  logic [1:0]        RM_SI,
  input  logic              SpecialNaN_SI,
  input  logic              SpecialInf_SI,
  input  logic              SpecialZero_SI,
  output logic              Valid_SO,
  input  logic              Ready_SI,
  output logic [31:0]       Result_DO,
  output logic              OF_SO,
  output logic              UF_SO,
  output logic              NX_SO
);

  localparam logic [1:0] C_RM_NEAREST  = 2'd0;
  localparam logic [1:0] C_RM_TRUNC    = 2'd1;
  localparam logic [1:0] C_RM_PLUSINF  = 2'd2;
  localparam logic [1:0] C_RM_MINUSINF = 2'd3;

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid;
  logic s1_load, s2_load;

  assign s2_load  = !s2_valid || Ready_SI;
  assign s1_load  = !s1_valid || s2_load;
  assign Ready_SO = s1_load;

  // ---------------- stage 1: normalize ----------------
  logic [25:0]        norm_mant;
  logic signed [10:0] norm_exp;
  logic               norm_sticky;
  logic               norm_tiny;

  logic [25:0]        s1_mant_d;
  logic signed [10:0] s1_exp_d;
  logic               s1_sticky_d;

  always_comb begin
    if (Mant_DI[26]) begin
      // Value in [2,4): bring the leading one down to bit 25.
      norm_mant   = Mant_DI[26:1];
      norm_exp    = 11'(Exp_DI) + 11'sd1;
      norm_sticky = Sticky_SI | Mant_DI[0];
    end else begin
      norm_mant   = Mant_DI[25:0];
      norm_exp    = 11'(Exp_DI);
      norm_sticky = Sticky_SI;
    end
    norm_tiny = (norm_exp <= 11'sd0);
  end

`ifdef DIV_SQRT_DENORM_EN
  logic [10:0] sh_raw;
  logic [4:0]  shamt;
  logic [25:0] lost_mask;

  always_comb begin
    // Shift so the value lands at exponent field 0 (weight 2^-126 on bit 25).
    // Beyond 26 places everything is already in sticky.
    sh_raw      = 11'd1 - norm_exp;
    shamt       = (sh_raw > 11'd26) ? 5'd26 : sh_raw[4:0];
    lost_mask   = (26'd1 << shamt) - 26'd1;
    s1_mant_d   = norm_mant;
    s1_exp_d    = norm_exp;
    s1_sticky_d = norm_sticky;
    if (norm_tiny) begin
      s1_mant_d   = norm_mant >> shamt;
      s1_exp_d    = 11'sd0;
      s1_sticky_d = norm_sticky | (|(norm_mant & lost_mask));
    end
  end
`else
  always_comb begin
    s1_mant_d   = norm_mant;
    s1_exp_d    = norm_exp;
    s1_sticky_d = norm_sticky;
  end
`endif

  logic [25:0]        s1_mant;
  logic signed [10:0] s1_exp;
  logic               s1_sticky, s1_sign, s1_tiny;
  logic [1:0]         s1_rm;
  logic               s1_nan, s1_inf, s1_zero;

  always_ff @(posedge Clk_CI) begin
    if (s1_load && Valid_SI) begin
      s1_mant   <= s1_mant_d;
      s1_exp    <= s1_exp_d;
      s1_sticky <= s1_sticky_d;
      s1_sign   <= Sign_DI;
      s1_tiny   <= norm_tiny;
      s1_rm     <= RM_SI;
      s1_nan    <= SpecialNaN_SI;
      s1_inf    <= SpecialInf_SI;
      s1_zero   <= SpecialZero_SI;
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic               inexact, round_up, carry, ovf;
  logic [24:0]        rounded;
  logic signed [11:0] exp_final;
  logic [31:0]        res_d;
  logic               of_d, uf_d, nx_d;

  always_comb begin
    inexact  = s1_mant[1] | s1_mant[0] | s1_sticky;
    round_up = 1'b0;
    case (s1_rm)
      C_RM_NEAREST:  round_up = s1_mant[1] & (s1_mant[0] | s1_sticky | s1_mant[2]);
      C_RM_TRUNC:    round_up = 1'b0;
      C_RM_PLUSINF:  round_up = inexact & !s1_sign;
      C_RM_MINUSINF: round_up = inexact & s1_sign;
      default:       round_up = 1'b0;
    endcase
    rounded = {1'b0, s1_mant[25:2]} + {24'd0, round_up};
    // A normal carries out of bit 24; a subnormal that reaches 2^-126 sets
    // bit 23, which is exactly exponent field 1 with fraction 0.
    carry     = s1_tiny ? rounded[23] : rounded[24];
    exp_final = {s1_exp[10], s1_exp} + {11'd0, carry};
    ovf       = !s1_tiny && (exp_final >= 12'sd255);

    res_d = {s1_sign, exp_final[7:0], rounded[22:0]};
    of_d  = ovf;
    nx_d  = inexact | ovf;
    uf_d  = s1_tiny & inexact;

    if (ovf) begin
      case (s1_rm)
        C_RM_NEAREST:  res_d = {s1_sign, 31'h7F800000};
        C_RM_TRUNC:    res_d = {s1_sign, 31'h7F7FFFFF};
        C_RM_PLUSINF:  res_d = s1_sign ? 32'hFF7FFFFF : 32'h7F800000;
        C_RM_MINUSINF: res_d = s1_sign ? 32'hFF800000 : 32'h7F7FFFFF;
        default:       res_d = {s1_sign, 31'h7F800000};
      endcase
    end

`ifndef DIV_SQRT_DENORM_EN
    if (s1_tiny) begin
      res_d = {s1_sign, 31'h0};
      of_d  = 1'b0;
      uf_d  = 1'b1;
      nx_d  = 1'b1;
    end
`endif

    if (s1_nan || s1_inf || s1_zero) begin
      of_d = 1'b0;
      uf_d = 1'b0;
      nx_d = 1'b0;
      if (s1_nan)      res_d = 32'h7FC00000;
      else if (s1_inf) res_d = {s1_sign, 31'h7F800000};
      else             res_d = {s1_sign, 31'h0};
    end
  end

  logic of_q, uf_q, nx_q;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      Result_DO <= 32'h0;
      of_q      <= 1'b0;
      uf_q      <= 1'b0;
      nx_q      <= 1'b0;
    end else if (Kill_SI) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load) s1_valid <= Valid_SI;
      if (s2_load) s2_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        Result_DO <= res_d;
        of_q      <= of_d;
        uf_q      <= uf_d;
        nx_q      <= nx_d;
      end
    end
  end

  assign Valid_SO = s2_valid;
  assign OF_SO    = s2_valid & of_q;
  assign UF_SO    = s2_valid & uf_q;
  assign NX_SO    = s2_valid & nx_q;

endmodule

// File: tb/tb_div_sqrt_norm_round.sv
// tb/tb_div_sqrt_norm_round.sv - directed self-checking bench for div_sqrt_norm_round

module tb_div_sqrt_norm_round;

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RTZ = 2'd1;
  localparam logic [1:0] RUP = 2'd2;
  localparam logic [1:0] RDN = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_out, kill;
  logic        sign;
  logic [9:0]  exp_in;
  logic [26:0] mant;
  logic        sticky;
  logic [1:0]  rm;
  logic        sp_nan, sp_inf, sp_zero;
  logic        valid_out, ready_in;
  logic [31:0] result;
  logic        of_f, uf_f, nx_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_sqrt_norm_round dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .Valid_SI      (valid_in),
    .Ready_SO      (ready_out),
    .Kill_SI       (kill),
    .Sign_DI       (sign),
    .Exp_DI        (exp_in),
    .Mant_DI       (mant),
    .Sticky_SI     (sticky),
    .RM_SI         (rm),
    .SpecialNaN_SI (sp_nan),
    .SpecialInf_SI (sp_inf),
    .SpecialZero_SI(sp_zero),
    .Valid_SO      (valid_out),
    .Ready_SI      (ready_in),
    .Result_DO     (result),
    .OF_SO         (of_f),
    .UF_SO         (uf_f),
    .NX_SO         (nx_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic sg, input logic [9:0] ex, input logic [26:0] mt,
                       input logic st, input logic [1:0] r, input logic [2:0] spc);
    sign    = sg;
    exp_in  = ex;
    mant    = mt;
    sticky  = st;
    rm      = r;
    sp_nan  = spc[2];
    sp_inf  = spc[1];
    sp_zero = spc[0];
  endtask

  // Entered and left at posedge+1 with Ready_SI high and the pipe empty.
  task automatic single(input string tag, input logic sg, input logic [9:0] ex,
                        input logic [26:0] mt, input logic st, input logic [1:0] r,
                        input logic [2:0] spc, input logic [31:0] res,
                        input logic eof, input logic euf, input logic enx);
    drive(sg, ex, mt, st, r, spc);
    valid_in = 1'b1;
    #1;
    check_eq({tag, "_ready"}, 32'(ready_out), 32'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check_eq({tag, "_lat1"}, 32'(valid_out), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_lat2"}, 32'(valid_out), 32'd1);
    check_eq({tag, "_res"}, result, res);
    check_eq({tag, "_flags"}, 32'({of_f, uf_f, nx_f}), 32'({eof, euf, enx}));
    @(posedge clk); #1;
    check_eq({tag, "_drain"}, 32'(valid_out), 32'd0);
  endtask

  logic        bp_sign [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [9:0]  bp_exp  [4] = '{10'd127, 10'd128, 10'd127, 10'd127};
  logic [26:0] bp_mant [4] = '{27'h2000000, 27'h2000000, 27'h2000000, 27'h3000000};
  logic [31:0] bp_res  [4] = '{32'h3F800000, 32'h40000000, 32'hBF800000, 32'h3FC00000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv, dup, stale;
    logic rdy;

    rst = 1'b1; kill = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    drive(1'b0, 10'd0, 27'd0, 1'b0, RNE, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_valid", 32'(valid_out), 32'd0);
    check_eq("reset_ready", 32'(ready_out), 32'd1);
    check_eq("reset_result", result, 32'h0);
    check_eq("reset_flags", 32'({of_f, uf_f, nx_f}), 32'd0);

    single("one",      1'b0, 10'd127, 27'h2000000, 1'b0, RNE, 3'b000, 32'h3F800000, 0, 0, 0);
    single("neg_one",  1'b1, 10'd127, 27'h2000000, 1'b0, RNE, 3'b000, 32'hBF800000, 0, 0, 0);
    single("rne_up",   1'b0, 10'd127, 27'h2000003, 1'b0, RNE, 3'b000, 32'h3F800001, 0, 0, 1);
    single("rtz",      1'b0, 10'd127, 27'h2000003, 1'b0, RTZ, 3'b000, 32'h3F800000, 0, 0, 1);
    single("tie_even", 1'b0, 10'd127, 27'h2000002, 1'b0, RNE, 3'b000, 32'h3F800000, 0, 0, 1);
    single("tie_odd",  1'b0, 10'd127, 27'h2000006, 1'b0, RNE, 3'b000, 32'h3F800002, 0, 0, 1);
    single("rup_pos",  1'b0, 10'd127, 27'h2000001, 1'b0, RUP, 3'b000, 32'h3F800001, 0, 0, 1);
    single("rdn_pos",  1'b0, 10'd127, 27'h2000001, 1'b0, RDN, 3'b000, 32'h3F800000, 0, 0, 1);
    single("norm_stk", 1'b0, 10'd127, 27'h4000001, 1'b0, RNE, 3'b000, 32'h40000000, 0, 0, 1);
    single("carry",    1'b0, 10'd127, 27'h3FFFFFE, 1'b0, RNE, 3'b000, 32'h40000000, 0, 0, 1);
    single("ovf_rne",  1'b0, 10'd254, 27'h4000000, 1'b0, RNE, 3'b000, 32'h7F800000, 1, 0, 1);
    single("ovf_rtz",  1'b0, 10'd254, 27'h4000000, 1'b0, RTZ, 3'b000, 32'h7F7FFFFF, 1, 0, 1);
    single("ovf_rup_n",1'b1, 10'd254, 27'h4000000, 1'b0, RUP, 3'b000, 32'hFF7FFFFF, 1, 0, 1);
    single("ovf_rdn_n",1'b1, 10'd254, 27'h4000000, 1'b0, RDN, 3'b000, 32'hFF800000, 1, 0, 1);
    single("ovf_carry",1'b0, 10'd254, 27'h3FFFFFF, 1'b0, RNE, 3'b000, 32'h7F800000, 1, 0, 1);
    single("min_norm", 1'b0, 10'd1,   27'h2000000, 1'b0, RNE, 3'b000, 32'h00800000, 0, 0, 0);
    single("sp_nan",   1'b1, 10'd127, 27'h2000003, 1'b1, RNE, 3'b100, 32'h7FC00000, 0, 0, 0);
    single("sp_inf",   1'b1, 10'd254, 27'h4000000, 1'b0, RNE, 3'b010, 32'hFF800000, 0, 0, 0);
    single("sp_zero",  1'b1, 10'd0,   27'h2000001, 1'b0, RNE, 3'b001, 32'h80000000, 0, 0, 0);
`ifdef DIV_SQRT_DENORM_EN
    single("tiny_exact",1'b0, 10'd0,    27'h2000000, 1'b0, RNE, 3'b000, 32'h00400000, 0, 0, 0);
    single("tiny_to_mn",1'b0, 10'd0,    27'h3FFFFFF, 1'b0, RNE, 3'b000, 32'h00800000, 0, 1, 1);
    single("tiny_deep", 1'b0, 10'h39C,  27'h2000000, 1'b0, RUP, 3'b000, 32'h00000001, 0, 1, 1);
`else
    single("tiny_exact",1'b0, 10'd0,    27'h2000000, 1'b0, RNE, 3'b000, 32'h00000000, 0, 1, 1);
    single("tiny_to_mn",1'b0, 10'd0,    27'h3FFFFFF, 1'b0, RNE, 3'b000, 32'h00000000, 0, 1, 1);
    single("tiny_deep", 1'b1, 10'h39C,  27'h2000000, 1'b0, RUP, 3'b000, 32'h80000000, 0, 1, 1);
`endif

    // Backpressure: Ready_SI low for the first 4 cycles, 4 inputs offered.
    sent = 0; recv = 0; dup = 0;
    for (int c = 0; c < 24; c++) begin
      ready_in = (c >= 4);
      #1;
      if (valid_out) begin
        if (recv >= 4) dup++;
        else if (ready_in) begin
          check_eq($sformatf("bp_out%0d", recv), result, bp_res[recv]);
          recv++;
        end else check_eq("bp_hold", result, bp_res[recv]);
      end
      if (c == 3) begin
        check_eq("bp_full_ready", 32'(ready_out), 32'd0);
        check_eq("bp_sent_at_stall", 32'(sent), 32'd2);
      end
      if (sent < 4) begin
        drive(bp_sign[sent], bp_exp[sent], bp_mant[sent], 1'b0, RNE, 3'b000);
        valid_in = 1'b1;
        rdy = ready_out;
      end else begin
        valid_in = 1'b0;
        rdy = 1'b0;
      end
      @(posedge clk); #1;
      if (rdy) sent++;
    end
    valid_in = 1'b0;
    check_eq("bp_sent", 32'(sent), 32'd4);
    check_eq("bp_recv", 32'(recv), 32'd4);
    check_eq("bp_dup", 32'(dup), 32'd0);

    // Reset with two operations in flight.
    ready_in = 1'b0;
    drive(1'b0, 10'd127, 27'h2000000, 1'b0, RNE, 3'b000);
    valid_in = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 10'd128, 27'h2000000, 1'b0, RNE, 3'b000);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check_eq("rst_pre_valid", 32'(valid_out), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_ready", 32'(ready_out), 32'd1);
    check_eq("rst_result", result, 32'h0);
    ready_in = 1'b1;
    stale = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid_out) stale++;
    end
    check_eq("rst_stale", 32'(stale), 32'd0);

    // Kill with two in flight plus a simultaneous new input while Ready_SO is high.
    ready_in = 1'b0;
    drive(1'b0, 10'd127, 27'h2000000, 1'b0, RNE, 3'b000);
    valid_in = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 10'd127, 27'h2000000, 1'b0, RNE, 3'b000);
    @(posedge clk); #1;
    ready_in = 1'b1;
    kill = 1'b1;
    drive(1'b0, 10'd128, 27'h2000000, 1'b0, RNE, 3'b000);
    #1;
    check_eq("kill_ready_high", 32'(ready_out), 32'd1);
    @(posedge clk); #1;
    kill = 1'b0;
    valid_in = 1'b0;
    check_eq("kill_valid", 32'(valid_out), 32'd0);
    stale = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (valid_out) stale++;
    end
    check_eq("kill_stale", 32'(stale), 32'd0);

    single("post_kill", 1'b0, 10'd128, 27'h3000000, 1'b0, RNE, 3'b000, 32'h40400000, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
